// File: rtl/prt_dprx_dscrm.sv
// DP RX descrambler: per-lane LFSR descrambling, SR->BS restore and SR-cadence lock monitor.
// Optional loss-of-lock counter is built when PRT_DPRX_DSCRM_LOL_CNT_EN is defined.

package prt_dp_pkg;
    localparam logic [7:0]  SYM_SR    = 8'h1C;
    localparam logic [7:0]  SYM_BS    = 8'hBC;
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;

    // Advance the G(X)=X^16+X^5+X^4+X^3+1 scrambler LFSR by one symbol (8 bit steps)
    function automatic logic [15:0] dp_lfsr_next8(input logic [15:0] s);
        logic [15:0] v;
        logic        fb;
        v = s;
        for (int n = 0; n < 8; n++) begin
            fb   = v[15];
            v    = {v[14:0], fb};
            v[3] = v[3] ^ fb;
            v[4] = v[4] ^ fb;
            v[5] = v[5] ^ fb;
        end
        return v;
    endfunction
endpackage

module prt_dprx_dscrm
    import prt_dp_pkg::*;
#(
    parameter int unsigned P_SIM     = 0,
    parameter int unsigned P_SPL     = 2,
    parameter int unsigned P_SR_TO   = 1048575,
    parameter int unsigned P_LOCK_SR = 2
)(
    input  logic                 CLK_IN,
    input  logic                 RST_IN,
    input  logic                 CTL_EN_IN,
    input  logic                 CTL_STA_CLR_IN,
    input  logic                 LNK_VLD_IN,
    input  logic [P_SPL-1:0]     LNK_K_IN,
    input  logic [8*P_SPL-1:0]   LNK_DAT_IN,
    output logic                 LNK_VLD_OUT,
    output logic [P_SPL-1:0]     LNK_K_OUT,
    output logic [8*P_SPL-1:0]   LNK_DAT_OUT,
    output logic                 STA_LOCK_OUT,
    output logic [15:0]          STA_LOL_CNT_OUT
);
    localparam int unsigned  WD_W   = 20;
    localparam int unsigned  CNT_W  = 4;
    localparam logic [WD_W-1:0]  WD_TO  = (P_SIM != 0) ? WD_W'(64) : WD_W'(P_SR_TO);
    localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(P_LOCK_SR);

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

    state_t                 r_state;
    logic                   r_en;
    logic                   r_vld;
    logic [P_SPL-1:0]       r_k;
    logic [8*P_SPL-1:0]     r_dat;
    logic [15:0]            r_lfsr;
    logic                   r_sr_prev;
    logic [WD_W-1:0]        r_wdog;
    logic [CNT_W-1:0]       r_sr_cnt;
    logic                   r_lock;

    logic [P_SPL-1:0][15:0] w_s;
    logic [P_SPL-1:0]       w_is_sr;
    logic [P_SPL-1:0]       w_k_nxt;
    logic [8*P_SPL-1:0]     w_dat_nxt;
    logic                   w_sr_evt;
    logic                   w_timeout;
    logic                   w_lol_evt;

    // Per-sublane LFSR chain and descrambled symbol
    always_comb begin
        w_s       = '0;
        w_is_sr   = '0;
        w_k_nxt   = LNK_K_IN;
        w_dat_nxt = LNK_DAT_IN;
        for (int i = 0; i < P_SPL; i++) begin
            w_is_sr[i] = LNK_K_IN[i] && (LNK_DAT_IN[8*i +: 8] == SYM_SR);
        end
        w_s[0] = r_sr_prev ? LFSR_SEED : dp_lfsr_next8(r_lfsr);
        for (int i = 1; i < P_SPL; i++) begin
            w_s[i] = w_is_sr[i-1] ? LFSR_SEED : dp_lfsr_next8(w_s[i-1]);
        end
        if (r_en) begin
            for (int i = 0; i < P_SPL; i++) begin
                if (w_is_sr[i]) begin
                    w_dat_nxt[8*i +: 8] = SYM_BS;
                end else if (!LNK_K_IN[i]) begin
                    for (int j = 0; j < 8; j++) begin
                        w_dat_nxt[8*i + j] = LNK_DAT_IN[8*i + j] ^ w_s[i][15 - j];
                    end
                end
            end
        end
    end

    assign w_sr_evt  = r_en && LNK_VLD_IN && (|w_is_sr);
    assign w_timeout = (r_wdog == WD_TO);
    assign w_lol_evt = (r_state == ST_LOCKED) && (!r_en || (!w_sr_evt && w_timeout));

    // Data path, LFSR state, watchdog and lock FSM
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            r_state   <= ST_UNLOCKED;
            r_en      <= 1'b0;
            r_vld     <= 1'b0;
            r_k       <= '0;
            r_dat     <= '0;
            r_lfsr    <= LFSR_SEED;
            r_sr_prev <= 1'b0;
            r_wdog    <= '0;
            r_sr_cnt  <= '0;
            r_lock    <= 1'b0;
        end else begin
            r_en  <= CTL_EN_IN;
            r_vld <= LNK_VLD_IN;
            r_k   <= w_k_nxt;
            r_dat <= w_dat_nxt;
            if (!r_en) begin
                r_lfsr    <= LFSR_SEED;
                r_sr_prev <= 1'b0;
                r_wdog    <= '0;
                r_sr_cnt  <= '0;
                r_state   <= ST_UNLOCKED;
                r_lock    <= 1'b0;
            end else begin
                if (LNK_VLD_IN) begin
                    r_lfsr    <= w_s[P_SPL-1];
                    r_sr_prev <= w_is_sr[P_SPL-1];
                end
                if (w_sr_evt) begin
                    r_wdog <= '0;
                end else if (!w_timeout) begin
                    r_wdog <= r_wdog + WD_W'(1);
                end
                // An SR arriving on the timeout cycle takes priority over the timeout
                case (r_state)
                    ST_UNLOCKED: begin
                        if (w_sr_evt) begin
                            r_sr_cnt <= r_sr_cnt + CNT_W'(1);
                            if ((r_sr_cnt + CNT_W'(1)) == LOCK_N) begin
                                r_state <= ST_LOCKED;
                                r_lock  <= 1'b1;
                            end
                        end else if (w_timeout) begin
                            r_sr_cnt <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_sr_evt && w_timeout) begin
                            r_state  <= ST_UNLOCKED;
                            r_lock   <= 1'b0;
                            r_sr_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state <= ST_UNLOCKED;
                        r_lock  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PRT_DPRX_DSCRM_LOL_CNT_EN
    logic [15:0] r_lol_cnt;

    // Saturating loss-of-lock counter; clear beats a coincident increment
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            r_lol_cnt <= '0;
        end else if (CTL_STA_CLR_IN) begin
            r_lol_cnt <= '0;
        end else if (w_lol_evt && (r_lol_cnt != 16'hFFFF)) begin
            r_lol_cnt <= r_lol_cnt + 16'd1;
        end
    end

    assign STA_LOL_CNT_OUT = r_lol_cnt;
`else
    logic w_unused_lol;
    assign w_unused_lol    = CTL_STA_CLR_IN ^ w_lol_evt;
    assign STA_LOL_CNT_OUT = '0;
`endif

    assign LNK_VLD_OUT  = r_vld;
    assign LNK_K_OUT    = r_k;
    assign LNK_DAT_OUT  = r_dat;
    assign STA_LOCK_OUT = r_lock;

endmodule

// File: tb/tb_prt_dprx_dscrm.sv
// Self-checking bench for prt_dprx_dscrm: vector table, hand-written lock/disable/reset
// sequences and randomized traffic against a keystream-position reference model.
module tb_prt_dprx_dscrm;
    localparam int unsigned SPL    = 2;
    localparam int          TO     = 64;
    localparam int          LOCK_N = 2;
    localparam int          KS_LEN = 65535;
`ifdef PRT_DPRX_DSCRM_LOL_CNT_EN
    localparam logic [15:0] LOL_ON = 16'd1;
`else
    localparam logic [15:0] LOL_ON = 16'd0;
`endif

    logic               CLK_IN;
    logic               RST_IN;
    logic               CTL_EN_IN;
    logic               CTL_STA_CLR_IN;
    logic               LNK_VLD_IN;
    logic [SPL-1:0]     LNK_K_IN;
    logic [8*SPL-1:0]   LNK_DAT_IN;
    logic               LNK_VLD_OUT;
    logic [SPL-1:0]     LNK_K_OUT;
    logic [8*SPL-1:0]   LNK_DAT_OUT;
    logic               STA_LOCK_OUT;
    logic [15:0]        STA_LOL_CNT_OUT;

    prt_dprx_dscrm #(
        .P_SIM     (1),
        .P_SPL     (SPL),
        .P_SR_TO   (1048575),
        .P_LOCK_SR (LOCK_N)
    ) dut (
        .CLK_IN          (CLK_IN),
        .RST_IN          (RST_IN),
        .CTL_EN_IN       (CTL_EN_IN),
        .CTL_STA_CLR_IN  (CTL_STA_CLR_IN),
        .LNK_VLD_IN      (LNK_VLD_IN),
        .LNK_K_IN        (LNK_K_IN),
        .LNK_DAT_IN      (LNK_DAT_IN),
        .LNK_VLD_OUT     (LNK_VLD_OUT),
        .LNK_K_OUT       (LNK_K_OUT),
        .LNK_DAT_OUT     (LNK_DAT_OUT),
        .STA_LOCK_OUT    (STA_LOCK_OUT),
        .STA_LOL_CNT_OUT (STA_LOL_CNT_OUT)
    );

    initial begin
        CLK_IN = 1'b0;
        forever #5 CLK_IN = ~CLK_IN;
    end

    int checks;
    int failures;

    // Keystream byte for each symbol position counted from the last SR (position 0 = first symbol after SR)
    logic [7:0] ks [KS_LEN];

    // Reference model state
    bit          m_en;
    bit          m_locked;
    int          m_pos;
    int          m_since;
    int          m_srs;
    logic [15:0] m_lol;
    logic              e_vld;
    logic [SPL-1:0]    e_k;
    logic [8*SPL-1:0]  e_dat;

    typedef struct packed {
        logic        vld;
        logic [1:0]  k;
        logic [15:0] dat;
        logic [1:0]  ek;
        logic [15:0] edat;
        logic        evld;
        logic        elock;
    } vec_t;

    vec_t tbl [14];

    task automatic gen_ks();
        logic [15:0] s;
        logic [7:0]  b;
        s = 16'hFFFF;
        for (int n = 0; n < KS_LEN; n++) begin
            b = '0;
            for (int j = 0; j < 8; j++) begin
                b[j] = s[15];
                s = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
            end
            ks[n] = b;
        end
    endtask

    task automatic model_reset();
        m_en     = 1'b0;
        m_locked = 1'b0;
        m_pos    = 1;
        m_since  = 0;
        m_srs    = 0;
        m_lol    = '0;
        e_vld    = 1'b0;
        e_k      = '0;
        e_dat    = '0;
    endtask

    task automatic model_step();
        logic [7:0] d;
        logic       kk;
        bit         sr;
        bit         any_sr;
        bit         was_locked;
        bit         tout;
        bit         evt;
        int         p;
        e_vld  = LNK_VLD_IN;
        p      = m_pos;
        any_sr = 1'b0;
        for (int i = 0; i < SPL; i++) begin
            d  = LNK_DAT_IN[8*i +: 8];
            kk = LNK_K_IN[i];
            sr = kk && (d == 8'h1C);
            if (m_en) begin
                if (sr) d = 8'hBC;
                else if (!kk) d = d ^ ks[p];
            end
            e_dat[8*i +: 8] = d;
            e_k[i] = kk;
            any_sr = any_sr | sr;
            p = sr ? 0 : (p + 1) % KS_LEN;
        end
        was_locked = m_locked;
        evt = m_en && LNK_VLD_IN && any_sr;
        if (!m_en) begin
            m_pos    = 1;
            m_since  = 0;
            m_locked = 1'b0;
            m_srs    = 0;
        end else begin
            if (LNK_VLD_IN) m_pos = p;
            tout = (m_since == TO);
            if (evt) m_since = 0;
            else if (m_since < TO) m_since++;
            if (evt) begin
                if (!m_locked) begin
                    m_srs++;
                    if (m_srs >= LOCK_N) m_locked = 1'b1;
                end
            end else if (tout) begin
                m_locked = 1'b0;
                m_srs    = 0;
            end
        end
`ifdef PRT_DPRX_DSCRM_LOL_CNT_EN
        if (CTL_STA_CLR_IN) m_lol = '0;
        else if (was_locked && !m_locked && m_lol != 16'hFFFF) m_lol = m_lol + 16'd1;
`endif
        m_en = CTL_EN_IN;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge CLK_IN);
        model_step();
        #1;
        chk("m_vld",  32'(LNK_VLD_OUT),     32'(e_vld));
        chk("m_k",    32'(LNK_K_OUT),       32'(e_k));
        chk("m_dat",  32'(LNK_DAT_OUT),     32'(e_dat));
        chk("m_lock", 32'(STA_LOCK_OUT),    32'(m_locked));
        chk("m_lol",  32'(STA_LOL_CNT_OUT), 32'(m_lol));
    endtask

    task automatic drive(input logic vld, input logic [1:0] k, input logic [15:0] dat);
        LNK_VLD_IN = vld;
        LNK_K_IN   = k;
        LNK_DAT_IN = dat;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 2'b00, 16'($urandom));
            cycle();
        end
    endtask

    task automatic send_sr();
        drive(1'b1, 2'b01, {8'($urandom), 8'h1C});
        cycle();
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_vld"},  32'(LNK_VLD_OUT),     32'd0);
        chk({name, "_k"},    32'(LNK_K_OUT),       32'd0);
        chk({name, "_dat"},  32'(LNK_DAT_OUT),     32'd0);
        chk({name, "_lock"}, 32'(STA_LOCK_OUT),    32'd0);
        chk({name, "_lol"},  32'(STA_LOL_CNT_OUT), 32'd0);
    endtask

    initial begin
        int r;
        int sr_rate;
        checks   = 0;
        failures = 0;
        gen_ks();

        // Vectors: sublane 0 in the low byte
        tbl[0]  = '{1'b1, 2'b01, 16'hFF1C, 2'b01, 16'h00BC, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 2'b00, 16'hC017, 2'b00, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 2'b01, 16'hFF1C, 2'b01, 16'h00BC, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 2'b11, 16'hBF1C, 2'b11, 16'hBFBC, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 2'b00, 16'hC017, 2'b00, 16'h0000, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 2'b11, 16'h1CBF, 2'b11, 16'hBCBF, 1'b1, 1'b1};
        for (int i = 6; i < 11; i++) begin
            tbl[i] = '{1'b0, 2'b00, 16'h0000, 2'b00, 16'h17FF, 1'b0, 1'b1};
        end
        tbl[11] = '{1'b1, 2'b00, 16'h17FF, 2'b00, 16'h0000, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 2'b11, 16'h1C1C, 2'b11, 16'hBCBC, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 2'b00, 16'h17FF, 2'b00, 16'h0000, 1'b1, 1'b1};

        RST_IN         = 1'b1;
        CTL_EN_IN      = 1'b0;
        CTL_STA_CLR_IN = 1'b0;
        drive(1'b0, 2'b00, 16'h0000);
        model_reset();
        #2;
        chk_zero("reset");
        repeat (2) @(posedge CLK_IN);
        #1;
        RST_IN    = 1'b0;
        CTL_EN_IN = 1'b1;
        cycle();
        cycle();

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].vld, tbl[i].k, tbl[i].dat);
            cycle();
            chk($sformatf("tbl%0d_dat", i),  32'(LNK_DAT_OUT),  32'(tbl[i].edat));
            chk($sformatf("tbl%0d_k", i),    32'(LNK_K_OUT),    32'(tbl[i].ek));
            chk($sformatf("tbl%0d_vld", i),  32'(LNK_VLD_OUT),  32'(tbl[i].evld));
            chk($sformatf("tbl%0d_lock", i), 32'(STA_LOCK_OUT), 32'(tbl[i].elock));
        end

        // Disable drops lock; clear held through the loss keeps the count at zero
        CTL_EN_IN      = 1'b0;
        CTL_STA_CLR_IN = 1'b1;
        idle(2);
        chk("dis_lock", 32'(STA_LOCK_OUT), 32'd0);
        chk("dis_clr_lol", 32'(STA_LOL_CNT_OUT), 32'd0);
        CTL_STA_CLR_IN = 1'b0;
        CTL_EN_IN      = 1'b1;
        idle(1);

        // Two SRs in one cycle are a single event
        drive(1'b1, 2'b11, 16'h1C1C);
        cycle();
        idle(39);
        chk("dbl_sr_one_evt", 32'(STA_LOCK_OUT), 32'd0);
        send_sr();
        chk("lock_2nd_sr", 32'(STA_LOCK_OUT), 32'd1);
        for (int n = 0; n < 3; n++) begin
            idle(39);
            send_sr();
            chk("lock_hold", 32'(STA_LOCK_OUT), 32'd1);
        end

        // SR landing exactly on the timeout cycle keeps lock
        idle(TO);
        send_sr();
        chk("sr_on_timeout", 32'(STA_LOCK_OUT), 32'd1);

        // No more SRs: lock lost once the watchdog expires
        idle(TO);
        chk("lock_pre_to", 32'(STA_LOCK_OUT), 32'd1);
        idle(1);
        chk("lol_timeout", 32'(STA_LOCK_OUT), 32'd0);
        chk("lol_cnt_1", 32'(STA_LOL_CNT_OUT), 32'(LOL_ON));

        // Clear coincident with a loss of lock wins
        send_sr();
        idle(39);
        send_sr();
        chk("relock", 32'(STA_LOCK_OUT), 32'd1);
        idle(TO);
        CTL_STA_CLR_IN = 1'b1;
        idle(1);
        CTL_STA_CLR_IN = 1'b0;
        chk("clr_lock", 32'(STA_LOCK_OUT), 32'd0);
        chk("clr_wins", 32'(STA_LOL_CNT_OUT), 32'd0);

        // Randomized traffic: dense SRs first, then sparse enough to time out
        for (int n = 0; n < 3000; n++) begin
            sr_rate = (n < 1500) ? 60 : 110;
            if ($urandom_range(0, 399) == 0) CTL_EN_IN = ~CTL_EN_IN;
            CTL_STA_CLR_IN = ($urandom_range(0, 99) == 0);
            LNK_VLD_IN     = ($urandom_range(0, 9) < 8);
            for (int i = 0; i < SPL; i++) begin
                r = int'($urandom_range(0, sr_rate - 1));
                if (r == 0) begin
                    LNK_K_IN[i] = 1'b1;
                    LNK_DAT_IN[8*i +: 8] = 8'h1C;
                end else if (r < 4) begin
                    LNK_K_IN[i] = 1'b1;
                    LNK_DAT_IN[8*i +: 8] = (r == 2) ? 8'hBF : 8'hBC;
                end else begin
                    LNK_K_IN[i] = 1'b0;
                    LNK_DAT_IN[8*i +: 8] = 8'($urandom);
                end
            end
            cycle();
        end
        CTL_STA_CLR_IN = 1'b0;

        // Drop enable mid-stream: raw passthrough two cycles later
        CTL_EN_IN = 1'b1;
        idle(3);
        send_sr();
        idle(2);
        CTL_EN_IN = 1'b0;
        drive(1'b1, 2'b00, 16'h1234);
        cycle();
        drive(1'b1, 2'b01, 16'h551C);
        cycle();
        chk("raw_dat", 32'(LNK_DAT_OUT), 32'h551C);
        chk("raw_k", 32'(LNK_K_OUT), 32'd1);
        chk("raw_lock", 32'(STA_LOCK_OUT), 32'd0);

        // Asynchronous reset mid-frame, then SR resynchronises
        CTL_EN_IN = 1'b1;
        idle(3);
        send_sr();
        idle(2);
        #2;
        RST_IN = 1'b1;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(posedge CLK_IN);
        #1;
        RST_IN = 1'b0;
        drive(1'b0, 2'b00, 16'h0000);
        cycle();
        drive(1'b1, 2'b01, 16'hFF1C);
        cycle();
        chk("resync_dat", 32'(LNK_DAT_OUT), 32'h00BC);
        drive(1'b1, 2'b00, 16'hC017);
        cycle();
        chk("resync_next", 32'(LNK_DAT_OUT), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
